// File: rtl/dragonfang_pkg.sv
// dragonfang_pkg: shared vector datapath types and writeback sizing
package dragonfang_pkg;
  localparam int VLEN = 64;
  localparam int TAG_W = 5;
  localparam int WRITEBACK_BUFFER_DEPTH = 4;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VLEN-1:0]  data;
  } data_packet_t;
endpackage

// File: rtl/writeback_result_buffer.sv
// result_buffer: synchronous FIFO of results with wrapping pointers, count and flush
module result_buffer import dragonfang_pkg::*; #(
  parameter int DEPTH = WRITEBACK_BUFFER_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  data_packet_t           wr_data,
  output data_packet_t           rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0] cnt_t;
  ptr_t wr_ptr, rd_ptr;
  data_packet_t mem [DEPTH];
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      count <= (push && !pop) ? count + cnt_t'(1) : (!push && pop) ? count - cnt_t'(1) : count;
    end
  end
  // storage carries no valid state, so it is never reset
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/writeback.sv
// writeback: result buffer toward the VRF write port with flush and optional bypass (WRITEBACK_BYPASS_EN)
module writeback import dragonfang_pkg::*; #(
  parameter int BUFFER_DEPTH = WRITEBACK_BUFFER_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  data_packet_t                  input_port,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic                          flush,
  output data_packet_t                  output_port,
  output logic                          output_valid,
  input  logic                          output_ready,
  output data_packet_t                  bypass_port,
  output logic                          bypass_valid,
  output logic [$clog2(BUFFER_DEPTH):0] occupancy
);
  typedef logic [$clog2(BUFFER_DEPTH):0] cnt_t;
  logic push, pop;
  // ready/valid depend only on the registered count, never on same-cycle inputs
  assign input_ready  = occupancy < cnt_t'(BUFFER_DEPTH);
  assign output_valid = occupancy != '0;
  assign push = input_valid && input_ready;
  assign pop  = output_valid && output_ready;
  result_buffer #(.DEPTH(BUFFER_DEPTH)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (input_port),
    .rd_data (output_port),
    .count   (occupancy)
  );
`ifdef WRITEBACK_BYPASS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      bypass_port  <= '0;
      bypass_valid <= 1'b0;
    end else if (push && !flush) begin
      bypass_port  <= input_port;
      bypass_valid <= 1'b1;
    end
  end
`else
  assign bypass_port  = '0;
  assign bypass_valid = 1'b0;
`endif
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: randomized scoreboard bench for writeback against a queue model
module tb_writeback;
  import dragonfang_pkg::*;
  localparam int D = WRITEBACK_BUFFER_DEPTH;
  logic clock = 0, reset = 1, input_valid = 0, flush = 0, output_ready = 0;
  data_packet_t input_port = '0;
  logic input_ready, output_valid, bypass_valid;
  data_packet_t output_port, bypass_port;
  logic [$clog2(D):0] occupancy;
  writeback dut (
    .clock(clock), .reset(reset), .input_port(input_port), .input_valid(input_valid),
    .input_ready(input_ready), .flush(flush), .output_port(output_port),
    .output_valid(output_valid), .output_ready(output_ready), .bypass_port(bypass_port),
    .bypass_valid(bypass_valid), .occupancy(occupancy)
  );
  always #5 clock = ~clock;
  int errors = 0, checks = 0, retired = 0;
  data_packet_t sb[$];
  int m_occ = 0, n_occ = 0;
  logic rs_prev = 1, acc_prev = 0, started = 0;
  data_packet_t pk_prev = '0, eb = '0;
  logic eb_v = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic iv, input data_packet_t pk, input logic ordy, input logic fl, input logic rs);
    logic acc, pp;
    @(posedge clock); #1;
    m_occ = n_occ;
    if (rs_prev) begin eb_v = 0; eb = '0; end
    else if (acc_prev) begin eb_v = 1; eb = pk_prev; end
    started = 1;
    input_valid = iv; input_port = pk; output_ready = ordy; flush = fl; reset = rs;
    acc = 0;
    if (rs || fl) begin
      sb.delete();
      n_occ = 0;
    end else begin
      acc = iv && (m_occ < D);
      pp = ordy && (m_occ != 0);
      if (acc) sb.push_back(pk);
      n_occ = m_occ + int'(acc) - int'(pp);
    end
    rs_prev = rs; acc_prev = acc; pk_prev = pk;
  endtask
  function automatic data_packet_t mk(input int tag, input logic [VLEN-1:0] d);
    data_packet_t p;
    p.tag = TAG_W'(tag);
    p.data = d;
    return p;
  endfunction
  always @(negedge clock) begin
    if (started) begin
      chk("occupancy", 128'(occupancy), 128'(m_occ));
      chk("input_ready", 128'(input_ready), 128'(m_occ < D));
      chk("output_valid", 128'(output_valid), 128'(m_occ != 0));
`ifdef WRITEBACK_BYPASS_EN
      chk("bypass_valid", 128'(bypass_valid), 128'(eb_v));
      chk("bypass_port", 128'(bypass_port), 128'(eb));
`else
      chk("bypass_valid", 128'(bypass_valid), 128'(0));
      chk("bypass_port", 128'(bypass_port), 128'(0));
`endif
      if (output_valid && output_ready && !flush && !reset) begin
        if (sb.size() == 0) chk("pop_when_empty", 128'(1), 128'(0));
        else begin
          chk("retire", 128'(output_port), 128'(sb.pop_front()));
          retired++;
        end
      end
    end
  end
  initial begin
    data_packet_t z = '0;
    step(0, z, 0, 0, 1);
    step(0, z, 0, 0, 0);
    // single push, 1-cycle latency, then drained
    step(1, mk(5, {8{8'hA5}}), 1, 0, 0);
    repeat (3) step(0, z, 1, 0, 0);
    // fill to full, fifth offer refused, drain in order
    for (int i = 1; i <= 5; i++) step(1, mk(i, VLEN'(i * 16)), 0, 0, 0);
    repeat (6) step(0, z, 1, 0, 0);
    // simultaneous push and pop at occupancy 2
    step(1, mk(1, 64'h11), 0, 0, 0);
    step(1, mk(2, 64'h22), 0, 0, 0);
    step(1, mk(7, 64'h77), 1, 0, 0);
    repeat (4) step(0, z, 1, 0, 0);
    // flush on a full buffer with concurrent push and pop
    for (int i = 1; i <= 4; i++) step(1, mk(i + 20, VLEN'(i)), 0, 0, 0);
    step(1, mk(11, 64'hBB), 1, 1, 0);
    repeat (3) step(0, z, 1, 0, 0);
    // bypass tracking then reset
    step(1, mk(3, 64'h1), 0, 0, 0);
    step(1, mk(9, 64'h2), 0, 0, 0);
    step(0, z, 1, 0, 0);
    step(0, z, 1, 0, 1);
    repeat (3) step(0, z, 1, 0, 0);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      data_packet_t p;
      p.tag = TAG_W'($urandom);
      p.data = {$urandom, $urandom};
      step(($urandom % 10) < 6, p, ($urandom % 10) < 6, ($urandom % 64) == 0, ($urandom % 250) == 0);
    end
    repeat (8) step(0, z, 1, 0, 0);
    if (retired < 100) chk("retired_count", 128'(retired), 128'(100));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
